sd_blk_crc_framer: RTL and testbench



---
 rtl/sd_pkg.sv | 29 ++
 rtl/sd_crc16_d8.sv | 36 +++
 rtl/sd_blk_crc_framer.sv | 177 +++++++++++++++++
 tb/tb_sd_blk_crc_framer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sd_pkg
//  Purpose : Shared constants and the state type for the SD block CRC framer
//            and the byte-wise CRC16 datapath.
//  Macros  : SD_BLK_START_TOKEN_EN adds the TOKEN state to the state type.
//  Revision: 1.0 - initial release
// ============================================================================
package sd_pkg;

  // CRC16 seed used at the start of each block (SD data lines seed with zero)
  localparam logic [15:0] CRC16_INIT     = 16'h0000;
  // CCITT polynomial x^16 + x^12 + x^5 + 1, implicit x^16 term dropped
  localparam logic [15:0] CRC16_POLY     = 16'h1021;
  // SPI-mode single-block data start token
  localparam logic [7:0]  SD_START_TOKEN = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_CRC_HI = 3'd2,
    ST_CRC_LO = 3'd3
`ifdef SD_BLK_START_TOKEN_EN
    , ST_TOKEN = 3'd4
`endif
  } sd_framer_state_t;

endpackage
`default_nettype wire

// File: rtl/sd_crc16_d8.sv
`default_nettype none
// ============================================================================
//  Module  : sd_crc16_d8
//  Purpose : Purely combinational one-byte update of the CCITT CRC16,
//            MSB of the data byte processed first. Shared by the write-path
//            framer and the read-path checker.
//  Ports   : data[7:0]  - byte to fold in
//            crc[15:0]  - current CRC value
//            next[15:0] - CRC after folding in data
//  Revision: 1.0 - initial release
// ============================================================================
import sd_pkg::*;

module sd_crc16_d8 (
  input  logic [7:0]  data,
  input  logic [15:0] crc,
  output logic [15:0] next
);

  logic [15:0] acc;

  // Eight unrolled shift steps; synthesis flattens this into an XOR network.
  always_comb begin
    acc = crc;
    for (int i = 7; i >= 0; i--) begin
      if (acc[15] ^ data[i]) begin
        acc = {acc[14:0], 1'b0} ^ CRC16_POLY;
      end else begin
        acc = {acc[14:0], 1'b0};
      end
    end
    next = acc;
  end

endmodule
`default_nettype wire

// File: rtl/sd_blk_crc_framer.sv
`default_nettype none
// ============================================================================
//  Module  : sd_blk_crc_framer
//  Purpose : Frames one fixed-length data block for the SD DAT-line
//            serializer: passes BLOCK_LEN data bytes through a single-entry
//            output register while folding them into a CRC16, then appends
//            the CRC high byte and low byte (m_last on the low byte).
//  Macros  : SD_BLK_START_TOKEN_EN - emit a 0xFE start token ahead of the
//            data (not covered by the CRC). Undefined: no token.
//  Ports   : clk, rst      - clock (rising edge), async active-high reset
//            start         - begins a block, honoured only when idle
//            s_valid/s_ready/s_data        - input byte stream
//            m_valid/m_ready/m_data/m_last - output byte stream
//            busy          - from accepted start until final handshake
//            done          - pulse the cycle after the m_last handshake
//            crc_out       - CRC of the last completed block
//  Revision: 1.0 - initial release
// ============================================================================
import sd_pkg::*;

module sd_blk_crc_framer #(
  parameter int BLOCK_LEN = 512,
  parameter int CNT_W     = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic        busy,
  output logic        done,
  output logic [15:0] crc_out
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

  sd_framer_state_t state_q, state_d;
  logic [15:0]      crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [15:0]      crc_out_q, crc_out_d;

  logic             can_load;
  logic             s_hs;
  logic [15:0]      crc_next;

  // Output register may be (re)loaded when empty or being drained this cycle
  assign can_load = !m_valid_q || m_ready;
  assign s_ready  = (state_q == ST_DATA) && can_load;
  assign s_hs     = s_valid && s_ready;

  sd_crc16_d8 u_crc (
    .data (s_data),
    .crc  (crc_q),
    .next (crc_next)
  );

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    crc_out_d = crc_out_q;

    // Drain: an accepted byte empties the register unless reloaded below.
    // The m_last handshake closes the block.
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      if (m_last_q) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        // busy_q still set means the m_last byte is pending: ignore start
        if (start && !busy_q) begin
          crc_d  = CRC16_INIT;
          cnt_d  = '0;
          busy_d = 1'b1;
`ifdef SD_BLK_START_TOKEN_EN
          state_d = ST_TOKEN;
`else
          state_d = ST_DATA;
`endif
        end
      end
`ifdef SD_BLK_START_TOKEN_EN
      ST_TOKEN: begin
        if (can_load) begin
          m_data_d  = SD_START_TOKEN;
          m_valid_d = 1'b1;
          state_d   = ST_DATA;
        end
      end
`endif
      ST_DATA: begin
        if (s_hs) begin
          m_data_d  = s_data;
          m_valid_d = 1'b1;
          crc_d     = crc_next;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = ST_CRC_HI;
          end
        end
      end
      ST_CRC_HI: begin
        if (can_load) begin
          m_data_d  = crc_q[15:8];
          m_valid_d = 1'b1;
          state_d   = ST_CRC_LO;
        end
      end
      ST_CRC_LO: begin
        if (can_load) begin
          m_data_d  = crc_q[7:0];
          m_valid_d = 1'b1;
          m_last_d  = 1'b1;
          crc_out_d = crc_q;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      crc_q     <= CRC16_INIT;
      cnt_q     <= '0;
      m_data_q  <= 8'h00;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      crc_out_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      crc_out_q <= crc_out_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign crc_out = crc_out_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_blk_crc_framer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_sd_blk_crc_framer
//  Purpose : Self-checking bench for sd_blk_crc_framer. Two instances:
//            BLOCK_LEN=512 and BLOCK_LEN=9. Expected CRCs come from known
//            constants or a table-driven CRC16 reference model.
//  Macros  : SD_BLK_START_TOKEN_EN - expects the 0xFE token first.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_sd_blk_crc_framer;

  logic clk = 1'b0;
  logic rst;
  logic start512, start9;
  logic s_valid;
  logic [7:0] s_data;
  logic m_ready;

  logic s_ready_a, m_valid_a, m_last_a, busy_a, done_a;
  logic [7:0] m_data_a;
  logic [15:0] crc_out_a;
  logic s_ready_b, m_valid_b, m_last_b, busy_b, done_b;
  logic [7:0] m_data_b;
  logic [15:0] crc_out_b;

  logic sel9;
  logic w_s_ready, w_m_valid, w_m_last, w_busy, w_done;
  logic [7:0] w_m_data;
  logic [15:0] w_crc_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] crc_tbl[256];

  typedef struct {
    logic [71:0] msg;
    logic [15:0] exp_crc;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  sd_blk_crc_framer #(.BLOCK_LEN(512), .CNT_W(13)) dut (
    .clk(clk), .rst(rst), .start(start512),
    .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
    .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a),
    .m_last(m_last_a), .busy(busy_a), .done(done_a), .crc_out(crc_out_a)
  );

  sd_blk_crc_framer #(.BLOCK_LEN(9), .CNT_W(13)) dut9 (
    .clk(clk), .rst(rst), .start(start9),
    .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
    .m_last(m_last_b), .busy(busy_b), .done(done_b), .crc_out(crc_out_b)
  );

  always_comb begin
    w_s_ready = sel9 ? s_ready_b : s_ready_a;
    w_m_valid = sel9 ? m_valid_b : m_valid_a;
    w_m_last  = sel9 ? m_last_b  : m_last_a;
    w_m_data  = sel9 ? m_data_b  : m_data_a;
    w_busy    = sel9 ? busy_b    : busy_a;
    w_done    = sel9 ? done_b    : done_a;
    w_crc_out = sel9 ? crc_out_b : crc_out_a;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: classic lookup-table CRC16/XMODEM (poly 0x1021, init 0)
  function automatic logic [15:0] ref_crc(input int len);
    logic [15:0] c = 16'h0000;
    for (int i = 0; i < len; i++)
      c = {c[7:0], 8'h00} ^ crc_tbl[c[15:8] ^ tx_q[i]];
    return c;
  endfunction

  task automatic run_block(input bit use9, input int len, input int bp, input int gap,
                           input bit poke, input int abort_after,
                           input logic [15:0] exp_crc, input string tag);
    int idx = 0, last_cnt = 0, last_pos = -1, done_ok = 0, done_bad = 0;
    int stab_bad = 0, hold = 0, mism = 0;
    bit last_hs = 0, prev_stall = 0, finished = 0, poked_d = 0, poked_l = 0;
    logic [7:0] prev_data = 8'h00;
    rx_q.delete();
    exp_q.delete();
`ifdef SD_BLK_START_TOKEN_EN
    exp_q.push_back(8'hFE);
`endif
    for (int i = 0; i < len; i++) exp_q.push_back(tx_q[i]);
    exp_q.push_back(exp_crc[15:8]);
    exp_q.push_back(exp_crc[7:0]);

    sel9 = use9;
    s_valid = 1'b0;
    m_ready = 1'b1;
    if (use9) start9 = 1'b1; else start512 = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      start512 = 1'b0;
      start9   = 1'b0;
      s_valid = (idx < len) && ($urandom_range(99) >= gap);
      s_data  = (idx < len) ? tx_q[idx] : 8'($urandom);
      m_ready = ($urandom_range(99) >= bp);
      if (hold > 0) begin m_ready = 1'b0; hold--; end
      if (poke && !poked_d && idx == len / 2) begin
        if (use9) start9 = 1'b1; else start512 = 1'b1;
        poked_d = 1;
      end
      if (poke && !poked_l && w_m_valid && w_m_last) begin
        m_ready = 1'b0;
        hold = 2;
        if (use9) start9 = 1'b1; else start512 = 1'b1;
        poked_l = 1;
      end
      @(negedge clk);
      if (prev_stall && (w_m_data !== prev_data || w_m_valid !== 1'b1)) stab_bad++;
      if (last_hs) begin
        if (w_done === 1'b1) done_ok++; else done_bad++;
        finished = 1;
      end else if (w_done !== 1'b0) done_bad++;
      prev_stall = w_m_valid && !m_ready;
      prev_data  = w_m_data;
      last_hs = 0;
      if (s_valid && w_s_ready) idx++;
      if (w_m_valid && m_ready) begin
        rx_q.push_back(w_m_data);
        if (w_m_last) begin last_cnt++; last_pos = rx_q.size(); last_hs = 1; end
      end
      if (abort_after >= 0 && idx == abort_after) break;
      @(posedge clk); #1;
    end
    start512 = 1'b0;
    start9   = 1'b0;
    if (abort_after >= 0) begin
      chk({tag, " abort_idx"}, idx, abort_after);
      return;
    end
    chk({tag, " finished"}, finished, 1);
    chk({tag, " out_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) mism++;
    chk({tag, " byte_mismatches"}, mism, 0);
    chk({tag, " last_count"}, last_cnt, 1);
    chk({tag, " last_pos"}, last_pos, exp_q.size());
    chk({tag, " crc_out"}, w_crc_out, exp_crc);
    chk({tag, " done_ok"}, done_ok, 1);
    chk({tag, " done_bad"}, done_bad, 0);
    chk({tag, " stall_stable"}, stab_bad, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, " busy_clear"}, w_busy, 0);
    chk({tag, " idle_m_valid"}, w_m_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " s_ready"}, s_ready_a, 0);
    chk({tag, " m_valid"}, m_valid_a, 0);
    chk({tag, " m_last"}, m_last_a, 0);
    chk({tag, " busy"}, busy_a, 0);
    chk({tag, " done"}, done_a, 0);
    chk({tag, " m_data"}, m_data_a, 8'h00);
    chk({tag, " crc_out"}, crc_out_a, 16'h0000);
  endtask

  initial begin
    logic [71:0] m;
    logic [15:0] c;
    for (int v = 0; v < 256; v++) begin
      c = 16'(v) << 8;
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      crc_tbl[v] = c;
    end

    rst = 1'b1; start512 = 1'b0; start9 = 1'b0; sel9 = 1'b0;
    s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    chk("reset dut9 busy", busy_b, 0);
    chk("reset dut9 crc_out", crc_out_b, 16'h0000);
    rst = 1'b0;
    @(posedge clk); #1;

    // 512 x 0xFF, no backpressure
    tx_q.delete();
    for (int i = 0; i < 512; i++) tx_q.push_back(8'hFF);
    run_block(0, 512, 0, 0, 0, -1, 16'h7FA1, "ff512");
`ifdef SD_BLK_START_TOKEN_EN
    chk("ff512 token_first", rx_q[0], 8'hFE);
    chk("ff512 count", rx_q.size(), 515);
`else
    chk("ff512 count", rx_q.size(), 514);
`endif
    chk("ff512 tail_hi", rx_q[rx_q.size()-2], 8'h7F);
    chk("ff512 tail_lo", rx_q[rx_q.size()-1], 8'hA1);

    // Table-driven 9-byte blocks
    vecs[0].msg = "123456789";
    vecs[0].exp_crc = 16'h31C3;
    vecs[1].msg = 72'h0;
    vecs[1].exp_crc = 16'h0000;
    for (int k = 2; k < 4; k++) begin
      tx_q.delete();
      for (int i = 0; i < 9; i++) tx_q.push_back(8'($urandom));
      m = 72'h0;
      for (int i = 0; i < 9; i++) m[71-8*i -: 8] = tx_q[i];
      vecs[k].msg = m;
      vecs[k].exp_crc = ref_crc(9);
    end
    for (int k = 0; k < 4; k++) begin
      tx_q.delete();
      m = vecs[k].msg;
      for (int i = 0; i < 9; i++) tx_q.push_back(m[71-8*i -: 8]);
      run_block(1, 9, (k == 3) ? 40 : 0, (k == 3) ? 40 : 0, 0, -1,
                vecs[k].exp_crc, $sformatf("blk9_v%0d", k));
      if (k == 0) begin
        chk("blk9_v0 crc_hi", rx_q[rx_q.size()-2], 8'h31);
        chk("blk9_v0 crc_lo", rx_q[rx_q.size()-1], 8'hC3);
      end
    end

    // Backpressure, gapped input, start pokes during DATA and pending m_last
    tx_q.delete();
    for (int i = 0; i < 512; i++) tx_q.push_back(8'hFF);
    run_block(0, 512, 50, 40, 1, -1, 16'h7FA1, "ff512_bp");

    // Independent second block with random data against the model
    tx_q.delete();
    for (int i = 0; i < 512; i++) tx_q.push_back(8'($urandom));
    run_block(0, 512, 30, 20, 1, -1, ref_crc(512), "rand512");

    // Mid-block reset, then a clean block
    tx_q.delete();
    for (int i = 0; i < 512; i++) tx_q.push_back(8'hFF);
    run_block(0, 512, 0, 0, 0, -1, 16'h7FA1, "pre_abort");
    run_block(0, 512, 0, 0, 0, 100, 16'h7FA1, "abort");
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_block(0, 512, 0, 0, 0, -1, 16'h7FA1, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
